key_event_classifier: RTL

//  Consumes one debounced key (stable level plus single-cycle rising-edge pulse) from the upstream debounce stage.

---
 rtl/key_event_classifier.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/key_event_classifier.sv
// Classifies debounced key presses into short press, long press and double click pulses.
// Optional auto-repeat while long-held is enabled by defining KEY_AUTO_REPEAT_EN.
module key_event_classifier #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned DCLICK_MS = 300,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_level,
    input  logic key_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_pulse,
    output logic busy
);

    localparam int unsigned CYC_PER_MS = (CLK_HZ / 1000 >= 1) ? CLK_HZ / 1000 : 1;
    localparam int unsigned LONG_CYC   = LONG_MS * CYC_PER_MS;
    localparam int unsigned DCLICK_CYC = DCLICK_MS * CYC_PER_MS;
    localparam int unsigned REPEAT_CYC = REPEAT_MS * CYC_PER_MS;
    localparam int unsigned MAX_LD     = (LONG_CYC > DCLICK_CYC) ? LONG_CYC : DCLICK_CYC;
    localparam int unsigned MAX_CYC    = (MAX_LD > REPEAT_CYC) ? MAX_LD : REPEAT_CYC;
    localparam int unsigned CNT_W      = ($clog2(MAX_CYC + 1) < 1) ? 1 : $clog2(MAX_CYC + 1);

    // Decisions are taken one cycle before the registered pulse appears.
    localparam int unsigned LONG_TH   = (LONG_CYC >= 2) ? LONG_CYC - 2 : 0;
    localparam int unsigned DCLICK_TH = (DCLICK_CYC >= 2) ? DCLICK_CYC - 2 : 0;

    localparam logic [CNT_W-1:0] LONG_TH_C   = CNT_W'(LONG_TH);
    localparam logic [CNT_W-1:0] DCLICK_TH_C = CNT_W'(DCLICK_TH);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

`ifdef KEY_AUTO_REPEAT_EN
    // Hold state is entered together with long_press, so one more cycle is counted.
    localparam int unsigned      REPEAT_TH   = (REPEAT_CYC >= 1) ? REPEAT_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] REPEAT_TH_C = CNT_W'(REPEAT_TH);
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESS1    = 3'd1,
        S_WAIT2     = 3'd2,
        S_LONG_HOLD = 3'd3,
        S_DBL_HOLD  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             dbl_q, dbl_d;
    logic             busy_q, busy_d;
`ifdef KEY_AUTO_REPEAT_EN
    logic             rpt_q, rpt_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            dbl_q   <= dbl_d;
            busy_q  <= busy_d;
        end
    end

`ifdef KEY_AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q <= 1'b0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
        rpt_d   = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (key_pulse) begin
                    state_d = S_PRESS1;
                end
            end
            S_PRESS1: begin
                if (cnt_q == LONG_TH_C) begin
                    long_d  = 1'b1;
                    state_d = S_LONG_HOLD;
                end else if (!key_level) begin
                    state_d = S_WAIT2;
                end
            end
            S_WAIT2: begin
                if (key_pulse) begin
                    dbl_d   = 1'b1;
                    state_d = S_DBL_HOLD;
                end else if (cnt_q == DCLICK_TH_C) begin
                    short_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_LONG_HOLD: begin
                if (!key_level) begin
                    state_d = S_IDLE;
`ifdef KEY_AUTO_REPEAT_EN
                end else if (cnt_q == REPEAT_TH_C) begin
                    rpt_d = 1'b1;
                    cnt_d = '0;
`endif
                end
            end
            S_DBL_HOLD: begin
                if (!key_level) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Busy covers the cycle an event is delivered, even if the FSM is back in idle.
        busy_d = (state_d != S_IDLE) | short_d | long_d | dbl_d;
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_click = dbl_q;
    assign busy         = busy_q;
`ifdef KEY_AUTO_REPEAT_EN
    assign repeat_pulse = rpt_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule
